// File: rtl/psg_pkg.sv
// psg_pkg: shared constants and types for the stereo PSG.
//   ATTEN_ROM    - 16-entry attenuation table, 2 dB per step, 13-bit levels
//   NM_*         - noise LFSR variants
//   NOISE_SEED   - LFSR seed per variant (a single 1 in the MSB)
//   latch_type_e - what a data byte is applied to
//   noise_reload - shift-period reload value for the noise rate counter
package psg_pkg;

    localparam int NM_SMS   = 0;  // 16-bit, taps 0^3
    localparam int NM_BBC   = 1;  // 15-bit, taps 0^1
    localparam int NM_TANDY = 2;  // 15-bit, taps 0^3

    localparam int LVL_W = 13;

    localparam logic [LVL_W-1:0] ATTEN_ROM [16] = '{
        13'h1FFF, 13'h196A, 13'h1430, 13'h1009,
        13'h0CBD, 13'h0A1E, 13'h0809, 13'h0662,
        13'h0512, 13'h0407, 13'h0333, 13'h028B,
        13'h0205, 13'h019B, 13'h0146, 13'h0000
    };

    localparam logic [15:0] NOISE_SEED [3] = '{16'h8000, 16'h4000, 16'h4000};

    typedef enum logic {
        LT_TONE  = 1'b0,
        LT_ATTEN = 1'b1
    } latch_type_e;

    // Rate 0/1/2 shift every 16/32/64 ticks; rate 3 is driven by tone2
    // and never uses the counter.
    function automatic logic [5:0] noise_reload(input logic [1:0] rate);
        case (rate)
            2'd0:    return 6'd15;
            2'd1:    return 6'd31;
            2'd2:    return 6'd63;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/psg_tone_gen.sv
// psg_tone_gen: one square-wave tone channel.
//   clk, rst : clock, async active-high reset
//   tick     : prescaler tick; the channel only advances on it
//   freq     : 10-bit half-period reload value
//   phase    : square-wave output bit
// freq <= 1 pins the phase high so the channel acts as a DC level for
// sample playback through the attenuator.
module psg_tone_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [9:0] freq,
    output logic       phase
);

    logic [9:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (tick) begin
            if (freq <= 10'd1) begin
                // counter parked at 0 so a later real freq toggles at once
                phase_d = 1'b1;
                cnt_d   = '0;
            end else if (cnt_q == '0) begin
                phase_d = ~phase_q;
                cnt_d   = freq;
            end else begin
                cnt_d = cnt_q - 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/psg_stereo.sv
// psg_stereo: SN76489-style PSG with stereo panning.
//   in_clk, in_rst : clock, async active-high reset
//   in_val         : write byte, shared by PSG and pan writes
//   in_wr          : PSG write strobe (acts on rising edge)
//   in_pan_wr      : pan write strobe (acts on rising edge)
//   out_l, out_r   : registered, saturating unsigned mixes
//   out_tick       : one-clock pulse per prescaler tick
// Three tone channels live in psg_tone_gen; noise LFSR and mixer are here.
module psg_stereo
    import psg_pkg::*;
#(
    parameter int DIV_LOG2   = 4,
    parameter int NOISE_MODE = 0,
    parameter int OUT_W      = 16
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [7:0]       in_val,
    input  logic             in_wr,
    input  logic             in_pan_wr,
    output logic [OUT_W-1:0] out_l,
    output logic [OUT_W-1:0] out_r,
    output logic             out_tick
);

    localparam int          LFSR_W = (NOISE_MODE == NM_SMS) ? 16 : 15;
    localparam int          TAP    = (NOISE_MODE == NM_BBC) ? 1 : 3;
    localparam logic [15:0] SEED   = NOISE_SEED[NOISE_MODE];
    // four terms each below 2^OUT_W never overflow OUT_W+2 bits
    localparam int          SUM_W  = OUT_W + 2;

    // ---------------- state ----------------
    logic                 old_wr_q, old_wr_d;
    logic                 old_pan_wr_q, old_pan_wr_d;
    logic [1:0]           latch_chan_q, latch_chan_d;
    latch_type_e          latch_type_q, latch_type_d;
    logic [2:0][9:0]      freq_q, freq_d;
    logic [3:0][3:0]      atten_q, atten_d;
    logic [2:0]           nctrl_q, nctrl_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [5:0]           ncnt_q, ncnt_d;
    logic [7:0]           pan_q, pan_d;
    logic [DIV_LOG2-1:0]  presc_q, presc_d;
    logic                 run_q, run_d;
    logic                 ph2_prev_q, ph2_prev_d;
    logic [OUT_W-1:0]     out_l_q, out_l_d;
    logic [OUT_W-1:0]     out_r_q, out_r_d;

    // ---------------- combinational ----------------
    logic                 tick;
    logic [2:0]           phase;
    logic                 wr_edge, pan_edge, is_latch;
    logic [1:0]           wchan;
    latch_type_e          wtype;
    logic                 ph2_rise, nshift, fb_bit;
    logic [15:0]          lfsr_shift;
    logic [3:0]           ch_bit;
    logic [3:0][LVL_W-1:0] lvl;
    logic [SUM_W-1:0]     sum_l, sum_r;

    // run_q keeps out_tick low in reset while the prescaler sits at 0
    assign tick = run_q && (presc_q == '0);

    for (genvar g = 0; g < 3; g++) begin : g_tone
        psg_tone_gen u_tone (
            .clk   (in_clk),
            .rst   (in_rst),
            .tick  (tick),
            .freq  (freq_q[g]),
            .phase (phase[g])
        );
    end

    always_comb begin
        old_wr_d     = in_wr;
        old_pan_wr_d = in_pan_wr;
        latch_chan_d = latch_chan_q;
        latch_type_d = latch_type_q;
        freq_d       = freq_q;
        atten_d      = atten_q;
        nctrl_d      = nctrl_q;
        lfsr_d       = lfsr_q;
        ncnt_d       = ncnt_q;
        pan_d        = pan_q;
        presc_d      = presc_q + DIV_LOG2'(1);
        run_d        = 1'b1;
        ph2_prev_d   = phase[2];

        wr_edge  = in_wr && !old_wr_q;
        pan_edge = in_pan_wr && !old_pan_wr_q;
        is_latch = in_val[7];
        // a data byte goes to whatever the last latch byte selected
        wchan    = is_latch ? in_val[6:5] : latch_chan_q;
        wtype    = is_latch ? latch_type_e'(in_val[4]) : latch_type_q;

        // ---- noise ----
        ph2_rise = phase[2] && !ph2_prev_q;
        if (nctrl_q[1:0] == 2'd3) begin
            nshift = ph2_rise;
        end else begin
            nshift = tick && (ncnt_q == '0);
            if (tick) ncnt_d = (ncnt_q == '0) ? noise_reload(nctrl_q[1:0]) : ncnt_q - 6'd1;
        end
        fb_bit     = nctrl_q[2] ? (lfsr_q[0] ^ lfsr_q[TAP]) : lfsr_q[0];
        lfsr_shift = {1'b0, lfsr_q[15:1]};
        lfsr_shift[LFSR_W-1] = fb_bit;
        if (nshift) lfsr_d = (lfsr_shift == '0) ? SEED : lfsr_shift;

        // ---- PSG write; a noise-ctrl write overrides a same-cycle shift ----
        if (wr_edge) begin
            if (is_latch) begin
                latch_chan_d = in_val[6:5];
                latch_type_d = latch_type_e'(in_val[4]);
            end
            if (wtype == LT_ATTEN) begin
                atten_d[wchan] = in_val[3:0];
            end else if (wchan == 2'd3) begin
                nctrl_d = in_val[2:0];
                lfsr_d  = SEED;
                ncnt_d  = noise_reload(in_val[1:0]);
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (wchan == 2'(i)) begin
                        if (is_latch) freq_d[i][3:0] = in_val[3:0];
                        else          freq_d[i][9:4] = in_val[5:0];
                    end
                end
            end
        end

        if (pan_edge) pan_d = in_val;

        // ---- mixer ----
        ch_bit = {lfsr_q[0], phase};
        sum_l  = '0;
        sum_r  = '0;
        for (int i = 0; i < 4; i++) begin
            lvl[i] = ch_bit[i] ? ATTEN_ROM[atten_q[i]] : '0;
            if (pan_q[4+i]) sum_l = sum_l + SUM_W'(lvl[i]);
            if (pan_q[i])   sum_r = sum_r + SUM_W'(lvl[i]);
        end
        out_l_d = (|sum_l[SUM_W-1:OUT_W]) ? {OUT_W{1'b1}} : sum_l[OUT_W-1:0];
        out_r_d = (|sum_r[SUM_W-1:OUT_W]) ? {OUT_W{1'b1}} : sum_r[OUT_W-1:0];
    end

    // Edge-detect history keeps sampling through reset, so a strobe held
    // high across reset release is not mistaken for a new write, while a
    // strobe that was low in reset can write on the first clock after it.
    always_ff @(posedge in_clk) begin
        old_wr_q     <= old_wr_d;
        old_pan_wr_q <= old_pan_wr_d;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            latch_chan_q <= 2'd0;
            latch_type_q <= LT_TONE;
            freq_q       <= '0;
            atten_q      <= {4{4'hF}};
            nctrl_q      <= '0;
            lfsr_q       <= SEED;
            ncnt_q       <= '0;
            pan_q        <= 8'hFF;
            presc_q      <= '0;
            run_q        <= 1'b0;
            ph2_prev_q   <= 1'b0;
            out_l_q      <= '0;
            out_r_q      <= '0;
        end else begin
            latch_chan_q <= latch_chan_d;
            latch_type_q <= latch_type_d;
            freq_q       <= freq_d;
            atten_q      <= atten_d;
            nctrl_q      <= nctrl_d;
            lfsr_q       <= lfsr_d;
            ncnt_q       <= ncnt_d;
            pan_q        <= pan_d;
            presc_q      <= presc_d;
            run_q        <= run_d;
            ph2_prev_q   <= ph2_prev_d;
            out_l_q      <= out_l_d;
            out_r_q      <= out_r_d;
        end
    end

    assign out_l    = out_l_q;
    assign out_r    = out_r_q;
    assign out_tick = tick;

endmodule

// File: tb/tb_psg_stereo.sv
// tb_psg_stereo: directed + randomized stimulus against a behavioural
// model of the PSG (integer arithmetic over per-channel state), compared
// every clock on out_l, out_r and out_tick.
module tb_psg_stereo;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic [7:0]  in_val;
    logic        in_wr;
    logic        in_pan_wr;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        out_tick;

    always #5 in_clk = ~in_clk;

    psg_stereo #(.DIV_LOG2(4), .NOISE_MODE(0), .OUT_W(16)) dut (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_val    (in_val),
        .in_wr     (in_wr),
        .in_pan_wr (in_pan_wr),
        .out_l     (out_l),
        .out_r     (out_r),
        .out_tick  (out_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // 2 dB steps: round(8191 * 10^(-i/10)), last entry silent
    int rom [16] = '{8191, 6506, 5168, 4105, 3261, 2590, 2057, 1634,
                     1298, 1031, 819, 651, 517, 411, 326, 0};
    localparam int DIV  = 16;
    localparam int SEED = 32768;

    int m_freq [3], m_cnt [3], m_ph [3], m_atten [4];
    int m_nctrl, m_lfsr, m_ncnt, m_pan, m_lchan, m_ltype, m_edges, m_ph2p;
    int m_old_wr = 0, m_old_pw = 0;
    int exp_l, exp_r, exp_tick;

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) begin m_freq[i] = 0; m_cnt[i] = 0; m_ph[i] = 0; end
        for (int i = 0; i < 4; i++) m_atten[i] = 15;
        m_nctrl = 0; m_lfsr = SEED; m_ncnt = 0; m_pan = 255;
        m_lchan = 0; m_ltype = 0; m_edges = 0; m_ph2p = 0;
        exp_l = 0; exp_r = 0; exp_tick = 0;
    endfunction

    function automatic void model_edge(input int rst, input int wr, input int pw, input int v);
        int l, r, lv, b, tick, rise, rate, shift, fb, ch, ty;
        if (rst != 0) begin
            m_reset();
            m_old_wr = wr; m_old_pw = pw;
            return;
        end
        // mix of the state visible before this edge
        l = 0; r = 0;
        for (int i = 0; i < 4; i++) begin
            b  = (i < 3) ? m_ph[i] : (m_lfsr & 1);
            lv = b ? rom[m_atten[i]] : 0;
            if ((m_pan >> (4 + i)) & 1) l += lv;
            if ((m_pan >> i) & 1)       r += lv;
        end
        exp_l = (l > 65535) ? 65535 : l;
        exp_r = (r > 65535) ? 65535 : r;

        tick = (m_edges > 0) && (m_edges % DIV == 0);
        rise = m_ph[2] && !m_ph2p;
        m_ph2p = m_ph[2];

        rate  = m_nctrl & 3;
        shift = (rate == 3) ? rise : (tick && m_ncnt == 0);
        if (rate != 3 && tick) m_ncnt = (m_ncnt == 0) ? (16 << rate) - 1 : m_ncnt - 1;
        if (shift) begin
            fb = ((m_nctrl >> 2) & 1) ? ((m_lfsr ^ (m_lfsr >> 3)) & 1) : (m_lfsr & 1);
            m_lfsr = (m_lfsr >> 1) | (fb << 15);
            if (m_lfsr == 0) m_lfsr = SEED;
        end

        for (int i = 0; i < 3; i++) begin
            if (tick) begin
                if (m_freq[i] <= 1) begin m_ph[i] = 1; m_cnt[i] = 0; end
                else if (m_cnt[i] == 0) begin m_ph[i] = 1 - m_ph[i]; m_cnt[i] = m_freq[i]; end
                else m_cnt[i]--;
            end
        end

        if (wr && !m_old_wr) begin
            if (v & 128) begin m_lchan = (v >> 5) & 3; m_ltype = (v >> 4) & 1; end
            ch = m_lchan; ty = m_ltype;
            if (ty == 1) m_atten[ch] = v & 15;
            else if (ch == 3) begin
                m_nctrl = v & 7;
                m_lfsr  = SEED;
                m_ncnt  = ((v & 3) == 3) ? 0 : (16 << (v & 3)) - 1;
            end else if (v & 128) m_freq[ch] = (m_freq[ch] & 'h3F0) | (v & 15);
            else                  m_freq[ch] = (m_freq[ch] & 15) | ((v & 63) << 4);
        end
        if (pw && !m_old_pw) m_pan = v;

        m_old_wr = wr; m_old_pw = pw;
        m_edges++;
        exp_tick = (m_edges % DIV == 0);
    endfunction

    // ---------------- stimulus helpers ----------------
    int max_l = 0;

    task automatic cyc(input logic w, input logic p, input logic [7:0] v);
        in_wr = w; in_pan_wr = p; in_val = v;
        @(posedge in_clk);
        model_edge(int'(in_rst), int'(w), int'(p), int'(v));
        #1;
        chk("out_l", int'(out_l), exp_l);
        chk("out_r", int'(out_r), exp_r);
        chk("out_tick", int'(out_tick), exp_tick);
        if (int'(out_l) > max_l) max_l = int'(out_l);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic wbyte(input logic [7:0] v);
        cyc(1'b1, 1'b0, v);
        cyc(1'b0, 1'b0, v);
    endtask

    task automatic pbyte(input logic [7:0] v);
        cyc(1'b0, 1'b1, v);
        cyc(1'b0, 1'b0, v);
    endtask

    function automatic logic [7:0] rnd_byte();
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0:       return 8'(8'h80 | ($urandom_range(0, 3) << 5) | $urandom_range(0, 15));
            1:       return 8'(8'h90 | ($urandom_range(0, 3) << 5) | $urandom_range(0, 4));
            2:       return 8'($urandom_range(0, 2));
            3:       return 8'(8'hE0 | $urandom_range(0, 7));
            default: return 8'($urandom);
        endcase
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        in_rst = 1'b1; in_wr = 1'b0; in_pan_wr = 1'b0; in_val = 8'h00;
        m_reset();
        #1;
        chk("rst_out_l", int'(out_l), 0);
        chk("rst_out_r", int'(out_r), 0);
        chk("rst_tick", int'(out_tick), 0);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        #2 in_rst = 1'b0;
        idle(40);

        // ch0 freq 0x01E, atten 0, full pan: 31-tick half periods
        wbyte(8'h8E); wbyte(8'h01); wbyte(8'h90); pbyte(8'hFF);
        idle(31 * DIV * 4);

        // data byte after an attenuation latch sets ch0 atten to 3
        wbyte(8'h9F); wbyte(8'h03);
        idle(31 * DIV * 2);

        // pan left-only with a same-cycle data write (ch0 atten back to 0)
        cyc(1'b1, 1'b1, 8'h10);
        cyc(1'b0, 1'b0, 8'h10);
        idle(31 * DIV * 2);
        pbyte(8'hFF);

        // white noise alone, rate 0
        wbyte(8'h9F); wbyte(8'hBF); wbyte(8'hDF); wbyte(8'hF0);
        wbyte(8'hE4);
        idle(21 * 16 * DIV);
        // rate 3: noise follows tone2 rising edges (ch2 freq 3)
        wbyte(8'hC3); wbyte(8'h00);
        wbyte(8'hE3);
        idle(2000);

        // all four at atten 0, tones DC, periodic noise until bit0 is high
        max_l = 0;
        wbyte(8'h80); wbyte(8'h00); wbyte(8'hA0); wbyte(8'h00);
        wbyte(8'hC0); wbyte(8'h00);
        wbyte(8'h90); wbyte(8'hB0); wbyte(8'hD0); wbyte(8'hF0);
        wbyte(8'hE0);
        idle(16 * 16 * DIV + 200);
        chk("mix_max_7ffc", max_l, 'h7FFC);

        // freq = 1 holds ch0 high
        wbyte(8'h81); wbyte(8'h00);
        wbyte(8'hBF); wbyte(8'hDF); wbyte(8'hFF);
        idle(200);

        // async reset mid-tone with in_wr held high across release
        wbyte(8'h8E); wbyte(8'h01); wbyte(8'h90);
        idle(300);
        #3 in_rst = 1'b1;
        m_reset();
        #1;
        chk("async_rst_l", int'(out_l), 0);
        chk("async_rst_r", int'(out_r), 0);
        chk("async_rst_tick", int'(out_tick), 0);
        cyc(1'b1, 1'b0, 8'h90);
        cyc(1'b1, 1'b0, 8'h90);
        #2 in_rst = 1'b0;
        repeat (40) cyc(1'b1, 1'b0, 8'h90);  // no write: held strobe
        cyc(1'b0, 1'b0, 8'h90);
        wbyte(8'h90);                        // fresh edge: ch0 audible, both sides
        idle(100);

        // randomized writes, pan writes and simultaneous strobes
        for (int it = 0; it < 700; it++) begin
            int k;
            logic [7:0] v;
            k = $urandom_range(0, 9);
            v = rnd_byte();
            if (k < 5) idle($urandom_range(1, 40));
            else if (k < 8) begin
                repeat ($urandom_range(1, 3)) cyc(1'b1, 1'b0, v);
                cyc(1'b0, 1'b0, v);
            end else if (k == 8) pbyte(8'($urandom));
            else begin
                cyc(1'b1, 1'b1, v);
                cyc(1'b0, 1'b0, v);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
